alu_exec_unit: RTL
==================

// Module: alu_exec_unit
// PURPOSE
//  Execute stage consuming the 4-bit Operation code produced by the ALU control
//  decode, together with both operands. Single-cycle ops: AND/OR/ADD/SUB/SLT.
//  Iterative op: MUL, a shift-add multiplier returning the low DATA_WIDTH bits.
//  valid/ready handshake on both sides. Result is buffered until the consumer takes it.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; also the MUL iteration count (>=2)
// PORTS
//  clk        in   1           rising-edge clock
//  rst_n      in   1           asynchronous active-low reset
//  in_valid   in   1           Operation/SrcA/SrcB valid
//  in_ready   out  1           unit can accept this cycle
//  Operation  in   4           0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 MUL
//  SrcA       in   DATA_WIDTH  operand A
//  SrcB       in   DATA_WIDTH  operand B
//  out_valid  out  1           ALUResult/Zero/IllegalOp valid
//  out_ready  in   1           consumer accepts result this cycle
//  ALUResult  out  DATA_WIDTH  registered result
//  Zero       out  1           registered (ALUResult == 0)
//  IllegalOp  out  1           registered: Operation was not in the table above
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   state=IDLE; out_valid=0; ALUResult=0; Zero=0; IllegalOp=0; MUL regs and counter=0.
//   A MUL in progress is aborted and its result is discarded.
//  Accept: handshake fires when in_valid && in_ready, sampled at the rising edge.
//   in_ready = (state==IDLE) && (!out_valid || out_ready). Back-to-back is allowed
//   when the consumer drains in the same cycle.
//  Output: when out_valid=1 && out_ready=0, ALUResult/Zero/IllegalOp hold stable.
//   out_valid falls on the edge where out_ready=1, unless a new result loads on that
//   same edge; in that case out_valid stays 1 with the new data.
//  States:
//   IDLE:
//    - Accept of a single-cycle op: result registered on the accept edge.
//      out_valid=1 in the next cycle, so latency is 1. Stay in IDLE.
//    - Accept of MUL: acc=0, mcand=SrcA, mplier=SrcB, cnt=0. Go to MUL.
//    - Accept of an unlisted code: ALUResult=0, Zero=1, IllegalOp=1, latency 1.
//   MUL:
//    - Each edge: if mplier[0], acc+=mcand; then mcand<<=1, mplier>>=1, cnt++.
//    - All arithmetic is mod 2^DATA_WIDTH.
//    - On the edge where cnt==DATA_WIDTH-1: ALUResult=final acc, out_valid=1,
//      go to IDLE. Latency is DATA_WIDTH+1 cycles from the accept cycle.
//    - in_ready=0 throughout. No early termination; latency is fixed.
//  Arithmetic:
//   - ADD/SUB wrap mod 2^DATA_WIDTH; overflow is not flagged.
//   - SLT is a signed compare; result is {0..0, (SrcA<SrcB)}.
//   - MUL is unsigned shift-add; the low half is identical for signed operands.
//   - Zero is computed from the value being written into ALUResult.
//   - IllegalOp=0 for every listed code.
//  Inputs are ignored when in_ready=0. Operands are captured only at accept;
//  later changes to SrcA/SrcB do not affect a MUL in progress.
// TESTING (DATA_WIDTH=32)
//  1. ADD 7+5 with out_ready=1 -> cycle after accept: out_valid=1, ALUResult=12, Zero=0.
//  2. SUB 9-9 then AND F0F0F0F0&0F0F0F0F back-to-back, out_ready=1
//     -> results 0 (Zero=1) then 0 (Zero=1) on consecutive cycles; in_ready stays 1.
//  3. MUL 0xFFFFFFFF*3 -> in_ready=0 for 32 cycles; out_valid at cycle 33 with
//     ALUResult=0xFFFFFFFD. SLT -1<1 -> ALUResult=1.
//  4. ADD 1+1 with out_ready=0 for 5 cycles -> ALUResult=2 held, in_ready=0;
//     out_ready=1 -> out_valid drops next edge.
//  5. Operation=4'b1111 -> IllegalOp=1, ALUResult=0, Zero=1, latency 1.
//  6. Drop rst_n at MUL cycle 10 -> out_valid=0 and in_ready=0 immediately;
//     after release, in_ready=1 and a fresh OR 0xA|0x5 returns 0xF.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage with single-cycle AND/OR/ADD/SUB/SLT and an iterative shift-add MUL.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : request handshake carrying Operation, SrcA, SrcB
//   out_valid/out_ready   : response handshake carrying ALUResult, Zero, IllegalOp
module alu_exec_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero,
  output logic                  IllegalOp
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                         OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_MUL = 4'b1000;
  typedef enum logic {IDLE, MUL} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, res_q, res_d;
  logic [DATA_WIDTH-1:0] alu_res, acc_step;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ov_q, ov_d, zero_q, zero_d, ill_q, ill_d, accept, legal, lt;
  // in_ready is forced low while reset is held so nothing is offered during reset
  assign in_ready  = rst_n && state_q == IDLE && (!ov_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = ov_q;
  assign ALUResult = res_q;
  assign Zero      = zero_q;
  assign IllegalOp = ill_q;
  assign lt        = $signed(SrcA) < $signed(SrcB);
  assign legal     = Operation inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_MUL};
  assign alu_res   = Operation == OP_AND ? SrcA & SrcB :
                     Operation == OP_OR  ? SrcA | SrcB :
                     Operation == OP_ADD ? SrcA + SrcB :
                     Operation == OP_SUB ? SrcA - SrcB :
                     Operation == OP_SLT ? {{(DATA_WIDTH-1){1'b0}}, lt} : '0;
  assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    zero_d   = zero_q;
    ill_d    = ill_q;
    ov_d     = ov_q && !out_ready;
    if (state_q == MUL) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(DATA_WIDTH-1)) begin
        state_d = IDLE;
        res_d   = acc_step;
        zero_d  = acc_step == '0;
        ill_d   = 1'b0;
        ov_d    = 1'b1;
      end
    end else if (accept) begin
      if (Operation == OP_MUL) begin
        state_d  = MUL;
        acc_d    = '0;
        mcand_d  = SrcA;
        mplier_d = SrcB;
        cnt_d    = '0;
      end else begin
        res_d  = alu_res;
        zero_d = alu_res == '0;
        ill_d  = !legal;
        ov_d   = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      zero_q   <= 1'b0;
      ill_q    <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      ill_q    <= ill_d;
      ov_q     <= ov_d;
    end
  end
endmodule
